// File: rtl/hazard_pkg.sv
// Shared hazard definitions: scoreboard slot layout, forwarding constants and default pipe geometry.
// Also imported by the decode and ALU forwarding mux so both sides agree on the slot encoding.
package hazard_pkg;

    localparam int DEF_PIPE_DEPTH = 3;
    localparam int DEF_REG_AW     = 5;
    localparam int FWD_REGFILE    = 0;

    // Slot dest field is sized for the widest register file any core variant uses (REG_AW <= 8).
    localparam int SLOT_DEST_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_DEST_W-1:0] dest;
        logic                   is_load;
    } slot_t;

endpackage

// File: rtl/hazard_match_prio.sv
// Youngest-match search of one source register across the scoreboard slots.
// Purely combinational; slot 1 (EX) has highest priority, no match returns FWD_REGFILE.
module hazard_match_prio
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  slot_t [PIPE_DEPTH:1] slots,
    input  logic [REG_AW-1:0]    src,
    input  logic                 src_used,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_is_load
);

    always_comb begin
        sel         = SEL_W'(FWD_REGFILE);
        sel_is_load = 1'b0;
        // Walk oldest to youngest so the last hit, the youngest writer, wins.
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (src_used && (src != '0) && slots[k].valid &&
                (slots[k].dest == SLOT_DEST_W'(src))) begin
                sel         = SEL_W'(k);
                sel_is_load = slots[k].is_load;
            end
        end
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: writer scoreboard, forward selects, load-use and branch-bubble stalls.
// Stall/issue/selects are combinational from slot state; HAZARD_PERF_CNT_EN adds saturating stall counters.
module decode_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int  PIPE_DEPTH      = DEF_PIPE_DEPTH,
    parameter int  REG_AW          = DEF_REG_AW,
    parameter int  LOAD_READY_SLOT = 2,
    parameter int  BR_BUBBLES      = 3,
    localparam int SEL_W           = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_is_load,
    input  logic              id_is_branch,
    input  logic              flush,
    output logic              stall,
    output logic              issue,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              br_busy,
    output logic [31:0]       perf_load_stalls,
    output logic [31:0]       perf_br_stalls
);

    localparam int BR_W = (BR_BUBBLES > 0) ? $clog2(BR_BUBBLES + 1) : 1;
    localparam logic [SEL_W-1:0] LOAD_READY_SEL = SEL_W'(LOAD_READY_SLOT);

    slot_t [PIPE_DEPTH:1] slots;
    slot_t                slot_in;
    logic [BR_W-1:0]      br_cnt;
    logic                 rs_is_load;
    logic                 rt_is_load;
    logic                 load_stall;
    logic                 br_stall;

    always_comb begin
        slot_in         = '0;
        slot_in.valid   = issue & id_wen & (id_dest != '0);
        slot_in.dest    = SLOT_DEST_W'(id_dest);
        slot_in.is_load = id_is_load;
    end

    // Slot 1 takes the issuing writer (or a bubble); older slots always advance so committed work drains.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slots <= '0;
        end else begin
            slots[1] <= slot_in;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
        end
    end

    hazard_match_prio #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rs (
        .slots       (slots),
        .src         (id_rs),
        .src_used    (id_rs_used),
        .sel         (fwd_rs_sel),
        .sel_is_load (rs_is_load)
    );

    hazard_match_prio #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rt (
        .slots       (slots),
        .src         (id_rt),
        .src_used    (id_rt_used),
        .sel         (fwd_rt_sel),
        .sel_is_load (rt_is_load)
    );

    assign load_stall = (rs_is_load & (fwd_rs_sel != '0) & (fwd_rs_sel < LOAD_READY_SEL)) |
                        (rt_is_load & (fwd_rt_sel != '0) & (fwd_rt_sel < LOAD_READY_SEL));
    assign br_stall   = (br_cnt != '0);
    assign stall      = id_valid & (load_stall | br_stall);
    assign issue      = id_valid & ~stall & ~flush;
    assign br_busy    = br_stall;

    // Bubbles start only when the branch actually issues, so a load-use stall delays them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt <= '0;
        end else if (flush) begin
            br_cnt <= '0;
        end else if (issue & id_is_branch) begin
            br_cnt <= BR_W'(BR_BUBBLES);
        end else if (br_cnt != '0) begin
            br_cnt <= br_cnt - BR_W'(1);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] load_stall_cnt;
    logic [31:0] br_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_stall_cnt <= '0;
            br_stall_cnt   <= '0;
        end else begin
            if (id_valid & load_stall & (load_stall_cnt != '1)) begin
                load_stall_cnt <= load_stall_cnt + 32'd1;
            end
            if (id_valid & br_stall & ~load_stall & (br_stall_cnt != '1)) begin
                br_stall_cnt <= br_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_load_stalls = load_stall_cnt;
    assign perf_br_stalls   = br_stall_cnt;
`else
    assign perf_load_stalls = '0;
    assign perf_br_stalls   = '0;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed scenarios plus randomized traffic against an age-based model.
module tb_decode_hazard_ctrl;

    localparam int PD  = 3;
    localparam int LRS = 2;
    localparam int BRB = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, id_is_branch, flush;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       stall, issue, br_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [31:0] perf_load_stalls, perf_br_stalls;

    int checks = 0;
    int errors = 0;

    // Model: every issued writer remembered with its issue cycle; age = cycles since issue.
    int         cyc = 0;
    int         wr_cyc[$];
    logic [4:0] wr_dest[$];
    bit         wr_ld[$];
    bit         br_live = 1'b0;
    int         br_cyc = 0;
    int         pl_exp = 0;
    int         pb_exp = 0;

    always #5 clk = ~clk;

    decode_hazard_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rs_used       (id_rs_used),
        .id_rt_used       (id_rt_used),
        .id_wen           (id_wen),
        .id_dest          (id_dest),
        .id_is_load       (id_is_load),
        .id_is_branch     (id_is_branch),
        .flush            (flush),
        .stall            (stall),
        .issue            (issue),
        .fwd_rs_sel       (fwd_rs_sel),
        .fwd_rt_sel       (fwd_rt_sel),
        .br_busy          (br_busy),
        .perf_load_stalls (perf_load_stalls),
        .perf_br_stalls   (perf_br_stalls)
    );

    function automatic int m_sel(input logic [4:0] r, input bit used, output bit ld);
        int best = 0;
        ld = 1'b0;
        if (used && r != 5'd0) begin
            for (int i = 0; i < wr_cyc.size(); i++) begin
                int age = cyc - wr_cyc[i];
                if (age >= 1 && age <= PD && wr_dest[i] == r && (best == 0 || age < best)) begin
                    best = age;
                    ld   = wr_ld[i];
                end
            end
        end
        return best;
    endfunction

    function automatic bit m_load_stall();
        bit l1, l2;
        int a1, a2;
        a1 = m_sel(id_rs, id_rs_used, l1);
        a2 = m_sel(id_rt, id_rt_used, l2);
        return (a1 != 0 && l1 && a1 < LRS) || (a2 != 0 && l2 && a2 < LRS);
    endfunction

    function automatic bit m_br_stall();
        return br_live && (cyc - br_cyc) >= 1 && (cyc - br_cyc) <= BRB;
    endfunction

    task automatic m_reset();
        wr_cyc.delete();
        wr_dest.delete();
        wr_ld.delete();
        br_live = 1'b0;
        pl_exp  = 0;
        pb_exp  = 0;
    endtask

    task automatic set_in(input bit v, input logic [4:0] rs, input bit rsu, input logic [4:0] rt,
                          input bit rtu, input bit wen, input logic [4:0] dest, input bit ld,
                          input bit br, input bit fl);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wen = wen; id_dest = dest; id_is_load = ld; id_is_branch = br; flush = fl;
    endtask

    // Commits the current cycle's decision into the model, then advances one clock.
    task automatic tick();
        bit ls, bs, st, iss;
        ls  = m_load_stall();
        bs  = m_br_stall();
        st  = id_valid && (ls || bs);
        iss = id_valid && !st && !flush;
        if (id_valid && ls) pl_exp++;
        else if (id_valid && bs) pb_exp++;
        if (iss && id_wen && id_dest != 5'd0) begin
            wr_cyc.push_back(cyc); wr_dest.push_back(id_dest); wr_ld.push_back(id_is_load);
        end
        if (iss && id_is_branch) begin br_live = 1'b1; br_cyc = cyc; end
        if (flush) br_live = 1'b0;
        @(posedge clk);
        cyc++;
        while (wr_cyc.size() > 0 && cyc - wr_cyc[0] > PD) begin
            void'(wr_cyc.pop_front()); void'(wr_dest.pop_front()); void'(wr_ld.pop_front());
        end
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_in(1, 3, 1, 4, 1, 1, 3, 1, 1, 0);
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_issue: got %0b want 1", issue); end
        checks++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
        checks++; if (br_busy !== 1'b0) begin errors++; $display("FAIL reset_br_busy: got %0b want 0", br_busy); end
        checks++; if (perf_load_stalls !== 32'd0 || perf_br_stalls !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_load_stalls, perf_br_stalls); end
        m_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 resetn = 1'b1;
        tick();
    endtask

    task automatic test_alu_b2b();
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_issue: got %0b want 1", issue); end
        tick();
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd_rs_sel !== 2'd1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_slot1: sel %0d stall %0b want 1/0", fwd_rs_sel, stall); end
        tick();
        set_in(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd_rt_sel !== 2'd2) begin errors++; $display("FAIL b2b_slot2: got %0d want 2", fwd_rt_sel); end
        tick();
        set_in(1, 3, 1, 3, 1, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd_rs_sel !== 2'd3 || fwd_rt_sel !== 2'd3) begin errors++; $display("FAIL b2b_slot3: got %0d/%0d want 3/3", fwd_rs_sel, fwd_rt_sel); end
        tick();
        #1;
        checks++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL b2b_retired: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
        tick();
        idle(3);
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); tick();
        set_in(1, 5, 1, 0, 0, 1, 6, 0, 0, 0); #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL load_use_stall: stall %0b issue %0b want 1/0", stall, issue); end
        tick();
        checks++; if (stall !== 1'b0 || issue !== 1'b1 || fwd_rs_sel !== 2'd2) begin errors++; $display("FAIL load_use_release: stall %0b issue %0b sel %0d want 0/1/2", stall, issue, fwd_rs_sel); end
        tick();
        idle(3);
    endtask

    task automatic test_branch();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL br_issue: got %0b want 1", issue); end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < BRB; i++) begin
            #1;
            checks++; if (stall !== 1'b1 || br_busy !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL br_bubble%0d: stall %0b busy %0b issue %0b want 1/1/0", i, stall, br_busy, issue); end
            tick();
        end
        #1;
        checks++; if (stall !== 1'b0 || br_busy !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL br_resume: stall %0b busy %0b issue %0b want 0/0/1", stall, br_busy, issue); end
        tick();
    endtask

    task automatic test_r0_prio();
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 1, 1, 7, 0, 0, 0); #1;
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL r0_writer: got %0d want 0", fwd_rt_sel); end
        tick();
        set_in(1, 7, 1, 7, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (fwd_rs_sel !== 2'd1) begin errors++; $display("FAIL prio_youngest: got %0d want 1", fwd_rs_sel); end
        checks++; if (fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL unused_operand: got %0d want 0", fwd_rt_sel); end
        tick();
        idle(3);
    endtask

    task automatic test_flush();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (br_busy !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL flush_pre: busy %0b stall %0b want 1/1", br_busy, stall); end
        tick();
        set_in(1, 0, 0, 0, 0, 1, 9, 0, 0, 1); #1;
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue: got %0b want 0", issue); end
        tick();
        set_in(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b0 || br_busy !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL flush_clear: stall %0b busy %0b issue %0b want 0/0/1", stall, br_busy, issue); end
        checks++; if (fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL flush_writer: got %0d want 0", fwd_rs_sel); end
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (br_busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_vs_branch: busy %0b stall %0b want 0/0", br_busy, stall); end
        tick();
        idle(3);
    endtask

    task automatic test_perf();
        resetn = 1'b0; #1; m_reset(); resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); tick();
            set_in(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); tick();
            tick();
            idle(3);
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < BRB + 1; i++) tick();
        idle(1);
        checks++; if (perf_load_stalls !== (PERF_EN ? 32'd4 : 32'd0)) begin errors++; $display("FAIL perf_load: got %0d want %0d", perf_load_stalls, PERF_EN ? 4 : 0); end
        checks++; if (perf_br_stalls !== (PERF_EN ? 32'd3 : 32'd0)) begin errors++; $display("FAIL perf_br: got %0d want %0d", perf_br_stalls, PERF_EN ? 3 : 0); end
    endtask

    task automatic test_async_reset();
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 0, 0); tick();
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0b want 1", stall); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL arst_ctrl: stall %0b issue %0b want 0/1", stall, issue); end
        checks++; if (fwd_rs_sel !== 2'd0 || br_busy !== 1'b0) begin errors++; $display("FAIL arst_state: sel %0d busy %0b want 0/0", fwd_rs_sel, br_busy); end
        checks++; if (perf_load_stalls !== 32'd0) begin errors++; $display("FAIL arst_perf: got %0d want 0", perf_load_stalls); end
        m_reset();
        #1 resetn = 1'b1;
        tick();
        idle(3);
    endtask

    task automatic test_random();
        bit ls, bs, st, iss, l;
        int a;
        for (int n = 0; n < 500; n++) begin
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 19) == 0);
            #1;
            ls  = m_load_stall();
            bs  = m_br_stall();
            st  = id_valid && (ls || bs);
            iss = id_valid && !st && !flush;
            checks++; if (stall !== st) begin errors++; $display("FAIL rnd_stall cyc %0d: got %0b want %0b", cyc, stall, st); end
            checks++; if (issue !== iss) begin errors++; $display("FAIL rnd_issue cyc %0d: got %0b want %0b", cyc, issue, iss); end
            checks++; if (br_busy !== bs) begin errors++; $display("FAIL rnd_br_busy cyc %0d: got %0b want %0b", cyc, br_busy, bs); end
            if (!st) begin
                a = m_sel(id_rs, id_rs_used, l);
                checks++; if (fwd_rs_sel !== 2'(a)) begin errors++; $display("FAIL rnd_rs_sel cyc %0d: got %0d want %0d", cyc, fwd_rs_sel, a); end
                a = m_sel(id_rt, id_rt_used, l);
                checks++; if (fwd_rt_sel !== 2'(a)) begin errors++; $display("FAIL rnd_rt_sel cyc %0d: got %0d want %0d", cyc, fwd_rt_sel, a); end
            end
            checks++; if (perf_load_stalls !== 32'(PERF_EN ? pl_exp : 0)) begin errors++; $display("FAIL rnd_perf_load cyc %0d: got %0d want %0d", cyc, perf_load_stalls, PERF_EN ? pl_exp : 0); end
            checks++; if (perf_br_stalls !== 32'(PERF_EN ? pb_exp : 0)) begin errors++; $display("FAIL rnd_perf_br cyc %0d: got %0d want %0d", cyc, perf_br_stalls, PERF_EN ? pb_exp : 0); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_branch();
        test_r0_prio();
        test_flush();
        test_perf();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Parametrised hazard controller for the decode stage.
- Tracks in-flight register writers in a PIPE_DEPTH-entry scoreboard shift pipe. Produces per-operand forwarding selects, load-use stalls and a configurable branch-bubble stall.
- Sits beside decode. Its stall output drives fetch/decode hold and bubble insertion into EX.

Parameters:
- PIPE_DEPTH, 3, number of tracked downstream stages (slot 1 = EX, slot 2 = MEM, slot 3 = WB).
- REG_AW, 5, register address width. Register 0 is hardwired zero.
- LOAD_READY_SLOT, 2, lowest slot index from which load data is forwardable. Range 1..PIPE_DEPTH.
- BR_BUBBLES, 3, stall cycles after a branch/jump issues. 0 disables.
- SEL_W, $clog2(PIPE_DEPTH+1), forward-select width (derived, not overridden).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs  in  REG_AW  source register 1
- id_rt  in  REG_AW  source register 2
- id_rs_used  in  1  instruction reads rs
- id_rt_used  in  1  instruction reads rt
- id_wen  in  1  instruction writes a register
- id_dest  in  REG_AW  destination register
- id_is_load  in  1  instruction is a load
- id_is_branch  in  1  branch/jump/jr
- flush  in  1  squash decode instruction and cancel branch bubbles
- stall  out  1  hold fetch/decode; bubble into EX
- issue  out  1  id_valid & ~stall & ~flush
- fwd_rs_sel  out  SEL_W  0 = regfile, k = forward from slot k
- fwd_rt_sel  out  SEL_W  same, for rt
- br_busy  out  1  branch bubble counter nonzero
- perf_load_stalls  out  32  see Optional Feature
- perf_br_stalls  out  32  see Optional Feature

Behaviour:
- Scoreboard: slots 1..PIPE_DEPTH, each {valid, dest, is_load}. Every cycle slot k+1 <= slot k.
- Slot 1 <= {issue & id_wen & (id_dest!=0), id_dest, id_is_load}. Otherwise slot 1 is invalid (bubble).
- Match(k, r): slot k valid & dest==r & r!=0 & operand used.
- fwd_*_sel: smallest k (youngest) with Match. 0 if none. Combinational from the current slots.
- load_stall: youngest match is a load at k < LOAD_READY_SLOT, for either used operand.
- br_stall: counter != 0.
- stall = id_valid & (load_stall | br_stall). Combinational.
- While stall is asserted, fwd selects are don't-care.
- Branch counter: on issue & id_is_branch, load BR_BUBBLES. Otherwise decrement when nonzero.
  - A branch issuing while the counter is nonzero is impossible, since stall blocks issue.
- Load-use stall precedes the branch counter: a branch waiting on a load does not start its bubbles until it issues.
- flush: forces slot 1 bubble and clears the counter that cycle. Slots 2+ shift normally (older work commits).
- Flush and branch issue in the same cycle: flush wins, counter = 0.
- Reset (asynchronous, any time including mid-stall): all slots invalid, counter 0, perf counters 0.
  - Therefore stall=0, issue=id_valid, fwd selects 0, br_busy=0.
- Latency: a writer issued in cycle N is visible in slot 1 at N+1 and leaves after slot PIPE_DEPTH at N+PIPE_DEPTH+1.
- A reader issued after that sees sel 0 (regfile assumed written; write-before-read regfile).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: perf_load_stalls increments each cycle with id_valid & load_stall. perf_br_stalls increments each cycle with id_valid & br_stall & ~load_stall. Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package hazard_pkg holds:
  - slot typedef {valid, dest, is_load};
  - FWD_REGFILE = 0 constant;
  - default PIPE_DEPTH/REG_AW constants, shared with the decode and ALU forwarding mux.
- One sub-module: hazard_match_prio. Takes the slot vector and one register. Outputs the youngest-match index and is_load flag. Instantiated twice (rs, rt).

Test Plan:
- ALU back-to-back: issue add r3 (wen, dest=3), then next cycle rs=3 -> fwd_rs_sel=1, stall=0. One cycle later with rt=3 -> fwd_rt_sel=2.
- Load-use: lw dest=5, then rs=5 used -> stall=1 for exactly 1 cycle (LOAD_READY_SLOT=2). Then issue with fwd_rs_sel=2.
- Branch bubbles: beq issues at cycle 10 -> stall=1, br_busy=1 in cycles 11-13 with id_valid held. Issue resumes at cycle 14. BR_BUBBLES=0 build -> no stall.
- Register 0 and priority: writers to r0 never forward. Two writers to r7 in slots 1 and 3 -> sel=1.
- Flush at cycle 12 during branch bubbles -> counter cleared, stall=0 at cycle 13. Flushed writer never appears in the slots.
- Async reset asserted mid load-stall -> all outputs at reset values immediately, without a clock edge. With HAZARD_PERF_CNT_EN, 4 load-stall cycles -> perf_load_stalls=4.
